// File: rtl/arb_pkg.sv
// Shared definitions for the eight-way round-robin arbiter and its encoder.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Rotate right by sh, so bit sh of v lands in bit 0 of the result.
    function automatic logic [N_REQ-1:0] rotate_right(input logic [N_REQ-1:0] v,
                                                      input logic [IDX_W-1:0] sh);
        logic [2*N_REQ-1:0] dbl;
        dbl = {v, v} >> sh;
        return dbl[N_REQ-1:0];
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder; the lowest set bit wins.
module prio_enc8
    import arb_pkg::*;
(
    input  logic [7:0] req,
    output logic [2:0] idx,
    output logic       valid
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight level-sensitive requesters with an optional
// hold timeout; grant, index, valid and timeout are all registered.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [7:0] HOLD_LAST = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    arb_state_t state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] owner, owner_nxt;
    logic [7:0] hold_cnt, hold_cnt_nxt;
    logic [7:0] gnt_nxt;
    logic [2:0] gnt_idx_nxt;
    logic       gnt_valid_nxt;
    logic       timeout_nxt;

    logic [7:0] rot_req;
    logic [2:0] enc_idx;
    logic       any;
    logic [2:0] sel;
    logic       owner_req;
    logic       hold_last;

    assign rot_req = rotate_right(req, ptr);

    // Rotation never clears bits, so the encoder's valid is the same as |req.
    prio_enc8 u_enc (
        .req   (rot_req),
        .idx   (enc_idx),
        .valid (any)
    );

    assign sel       = enc_idx + ptr;
    assign owner_req = req[owner];
    assign hold_last = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        owner_nxt     = owner;
        hold_cnt_nxt  = hold_cnt;
        gnt_nxt       = gnt;
        gnt_idx_nxt   = gnt_idx;
        gnt_valid_nxt = gnt_valid;
        timeout_nxt   = 1'b0;

        case (state)
            ARB_IDLE: begin
                gnt_nxt       = '0;
                gnt_valid_nxt = 1'b0;
                if (enable && any) begin
                    state_nxt     = ARB_BUSY;
                    owner_nxt     = sel;
                    gnt_nxt       = 8'b1 << sel;
                    gnt_idx_nxt   = sel;
                    gnt_valid_nxt = 1'b1;
                    hold_cnt_nxt  = '0;
                end
            end
            ARB_BUSY: begin
                // A release on the limit cycle wins, so timeout only fires
                // when the owner is still requesting.
                if (!owner_req || hold_last) begin
                    state_nxt     = ARB_IDLE;
                    gnt_nxt       = '0;
                    gnt_valid_nxt = 1'b0;
                    ptr_nxt       = owner + 3'd1;
                    timeout_nxt   = owner_req;
                end else if (hold_cnt != 8'hFF) begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            owner     <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            hold_cnt  <= hold_cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= gnt_idx_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: four instances with hold limits 16, 4, 1 and 0 share
// one stimulus stream and are checked against tables and a reference model.
module tb_rr_arbiter8;

    localparam int N_DUT = 4;
    // Instance g uses HOLDS[g*8 +: 8]: inst0=16, inst1=4, inst2=1, inst3=0.
    localparam logic [31:0] HOLDS = {8'd0, 8'd1, 8'd4, 8'd16};

    typedef struct packed {
        logic [7:0] req;
        logic       en;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] req;

    logic [7:0] gnt_w   [N_DUT];
    logic [2:0] idx_w   [N_DUT];
    logic       valid_w [N_DUT];
    logic       to_w    [N_DUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        rr_arbiter8 #(
            .MAX_HOLD ({24'd0, HOLDS[g*8 +: 8]})
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .enable    (enable),
            .req       (req),
            .gnt       (gnt_w[g]),
            .gnt_idx   (idx_w[g]),
            .gnt_valid (valid_w[g]),
            .timeout   (to_w[g])
        );
    end

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state per instance, kept as plain integers.
    bit         m_busy  [N_DUT];
    int         m_owner [N_DUT];
    int         m_ptr   [N_DUT];
    int         m_cnt   [N_DUT];
    logic [7:0] m_gnt   [N_DUT];
    logic [2:0] m_idx   [N_DUT];
    logic       m_valid [N_DUT];
    logic       m_to    [N_DUT];

    function automatic void model_reset();
        for (int g = 0; g < N_DUT; g++) begin
            m_busy[g]  = 1'b0;
            m_owner[g] = 0;
            m_ptr[g]   = 0;
            m_cnt[g]   = 0;
            m_gnt[g]   = 8'h00;
            m_idx[g]   = 3'd0;
            m_valid[g] = 1'b0;
            m_to[g]    = 1'b0;
        end
    endfunction

    // One clock edge of the spec's behaviour, using the inputs seen at that edge.
    function automatic void model_step();
        for (int g = 0; g < N_DUT; g++) begin
            int h;
            int pick;
            bit found;
            h        = int'(HOLDS[g*8 +: 8]);
            m_to[g]  = 1'b0;
            found    = 1'b0;
            pick     = 0;
            if (!m_busy[g]) begin
                for (int k = 0; k < 8; k++) begin
                    if (!found && req[(m_ptr[g] + k) % 8]) begin
                        found = 1'b1;
                        pick  = (m_ptr[g] + k) % 8;
                    end
                end
                if (enable && found) begin
                    m_busy[g]  = 1'b1;
                    m_owner[g] = pick;
                    m_cnt[g]   = 0;
                    m_gnt[g]   = 8'b1 << pick;
                    m_idx[g]   = 3'(pick);
                    m_valid[g] = 1'b1;
                end else begin
                    m_gnt[g]   = 8'h00;
                    m_valid[g] = 1'b0;
                end
            end else if (!req[m_owner[g]] || (h != 0 && m_cnt[g] == h - 1)) begin
                m_to[g]    = req[m_owner[g]];
                m_busy[g]  = 1'b0;
                m_ptr[g]   = (m_owner[g] + 1) % 8;
                m_gnt[g]   = 8'h00;
                m_valid[g] = 1'b0;
            end else if (m_cnt[g] < 255) begin
                m_cnt[g] = m_cnt[g] + 1;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input int g, input logic [7:0] eg,
                               input logic [2:0] ei, input logic ev, input logic et);
        n_vec++;
        if (gnt_w[g] !== eg || idx_w[g] !== ei || valid_w[g] !== ev || to_w[g] !== et) begin
            n_bad++;
            $display("[TB] FAIL %s inst%0d: got gnt=%h idx=%0d valid=%b timeout=%b, want gnt=%h idx=%0d valid=%b timeout=%b",
                     name, g, gnt_w[g], idx_w[g], valid_w[g], to_w[g], eg, ei, ev, et);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] r, input logic e);
        @(negedge clk);
        req    = r;
        enable = e;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Reset lands mid-cycle so the outputs must clear without a clock edge.
    task automatic doReset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < N_DUT; g++)
            checkOutput("reset_async", g, 8'h00, 3'd0, 1'b0, 1'b0);
        model_reset();
        req    = 8'h00;
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t       tbl [21];
    logic [7:0] bitm;
    logic [7:0] req_r;
    logic       en_r;
    int         h_cur;
    logic [7:0] eg;
    logic [2:0] ei;
    logic       ev;
    logic       et;

    initial begin
        rst_n  = 1'b0;
        req    = 8'h00;
        enable = 1'b0;
        model_reset();
        doReset();

        // Single requester, ptr advance to 4, wrap from ptr 6, enable gating.
        tbl[0]  = '{8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[1]  = '{8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[2]  = '{8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[3]  = '{8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[4]  = '{8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[5]  = '{8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0};
        tbl[6]  = '{8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0};
        tbl[7]  = '{8'h11, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0};
        tbl[8]  = '{8'h00, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0};
        tbl[9]  = '{8'h21, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0};
        tbl[10] = '{8'h00, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0};
        tbl[11] = '{8'h21, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[12] = '{8'h20, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[13] = '{8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0};
        tbl[14] = '{8'h00, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0};
        tbl[15] = '{8'h10, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0};
        tbl[16] = '{8'h10, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0};
        tbl[17] = '{8'h10, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0};
        tbl[18] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
        tbl[19] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
        tbl[20] = '{8'h00, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0};
        for (int i = 0; i < 21; i++) begin
            applyStimulus(tbl[i].req, tbl[i].en);
            checkOutput($sformatf("table%0d", i), 0, tbl[i].gnt, tbl[i].idx, tbl[i].valid, tbl[i].to);
        end

        // Rotation under full load: owners 0..7 then 0 again, idle cycle between.
        doReset();
        for (int k = 0; k < 9; k++) begin
            bitm = 8'b1 << (k % 8);
            applyStimulus(8'hFF, 1'b1);
            checkOutput("rot_grant", 0, bitm, 3'(k % 8), 1'b1, 1'b0);
            applyStimulus(8'hFF, 1'b1);
            checkOutput("rot_hold", 0, bitm, 3'(k % 8), 1'b1, 1'b0);
            applyStimulus(8'hFF & ~bitm, 1'b1);
            checkOutput("rot_idle", 0, 8'h00, 3'(k % 8), 1'b0, 1'b0);
        end

        // Owner 0 never releases: each instance cycles grant/timeout by its limit.
        doReset();
        for (int c = 0; c < 300; c++) begin
            applyStimulus(8'h01, 1'b1);
            for (int g = 0; g < N_DUT; g++) begin
                h_cur = int'(HOLDS[g*8 +: 8]);
                if (h_cur != 0 && (c % (h_cur + 1)) == h_cur)
                    checkOutput("hold_timeout", g, 8'h00, 3'd0, 1'b0, 1'b1);
                else
                    checkOutput("hold_grant", g, 8'h01, 3'd0, 1'b1, 1'b0);
            end
        end

        // After a timeout on owner 0, requester 1 is next in line.
        doReset();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(8'h03, 1'b1);
            if (c < 4) begin
                eg = 8'h01; ei = 3'd0; ev = 1'b1; et = 1'b0;
            end else if (c == 4) begin
                eg = 8'h00; ei = 3'd0; ev = 1'b0; et = 1'b1;
            end else begin
                eg = 8'h02; ei = 3'd1; ev = 1'b1; et = 1'b0;
            end
            checkOutput("timeout_next", 1, eg, ei, ev, et);
        end

        // Release on the very cycle the limit is reached counts as a release.
        doReset();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(8'h01, 1'b1);
            checkOutput("limit_hold", 1, 8'h01, 3'd0, 1'b1, 1'b0);
        end
        applyStimulus(8'h00, 1'b1);
        checkOutput("limit_release", 1, 8'h00, 3'd0, 1'b0, 1'b0);

        // Reset while busy with ptr at 4 must bring ptr back to 0.
        doReset();
        applyStimulus(8'h08, 1'b1);
        checkOutput("rst_pre_grant", 0, 8'h08, 3'd3, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b1);
        checkOutput("rst_pre_release", 0, 8'h00, 3'd3, 1'b0, 1'b0);
        applyStimulus(8'h20, 1'b1);
        checkOutput("rst_busy", 0, 8'h20, 3'd5, 1'b1, 1'b0);
        doReset();
        applyStimulus(8'h12, 1'b1);
        checkOutput("rst_ptr_zero", 0, 8'h02, 3'd1, 1'b1, 1'b0);

        // Random traffic against the reference model on every instance.
        doReset();
        req_r = 8'h00;
        en_r  = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0)
                req_r = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 7) == 0)
                en_r = ~en_r;
            if ($urandom_range(0, 249) == 0)
                doReset();
            applyStimulus(req_r, en_r);
            for (int g = 0; g < N_DUT; g++)
                checkOutput("random", g, m_gnt[g], m_idx[g], m_valid[g], m_to[g]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one downstream resource among eight requesters, such as a bus port or a datapath slot fed by the 8-to-3 encoder path. It accepts a request vector and grants exactly one requester at a time. A grant is held until the owner releases it or a hold timeout revokes it. Priority then rotates to the requester after the last owner. Outputs are a one-hot grant and its 3-bit binary index, so the index can drive downstream mux selects directly.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum cycles a grant may be held. 0 disables the timeout. Legal range is 0 to 255.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset. Asynchronous and active-low.
- `enable`  in  1  allows new grants. It does not affect a grant already in progress.
- `req`  in  8  request vector. Bit i is requester i and is level-sensitive.
- `gnt`  out  8  one-hot grant. Registered.
- `gnt_idx`  out  3  binary index of the current owner. Registered. Holds the last owner's index while idle.
- `gnt_valid`  out  1  high while any grant is active. Registered.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the hold timeout. Registered.

## Operation
- States: `IDLE` and `BUSY`.
- Internal registers:
  - `ptr[2:0]` holds the highest-priority index.
  - `owner[2:0]` holds the current owner.
  - `hold_cnt[7:0]` counts grant cycles.
- Selection is combinational and evaluated in `IDLE` only:
  1. Rotate `req` right by `ptr`.
  2. Priority-encode the result so the lowest set bit wins.
  3. Compute `sel = (enc + ptr) mod 8`.
  4. `any = |req`.
- `IDLE` → `BUSY` when `enable && any`:
  - `owner = sel`, `gnt = 1<<sel`, `gnt_idx = sel`, `gnt_valid = 1`, `hold_cnt = 0`.
- `IDLE` with `!enable || !any`: stay in `IDLE` with all grant outputs 0.
- `BUSY`, release: when `req[owner] == 0`, return to `IDLE`.
  - `gnt = 0`, `gnt_valid = 0`, `ptr = owner+1` (3-bit wrap, so 7→0).
- `BUSY`, timeout: when `MAX_HOLD != 0`, `req[owner] == 1` and `hold_cnt == MAX_HOLD-1`:
  - Do the same as release.
  - Also set `timeout = 1` for one cycle.
- `BUSY` otherwise: `hold_cnt++`, outputs unchanged.
- Requests from non-owners during `BUSY` are ignored. Nothing is queued, because `req` is level-sensitive.
- Dropping `enable` during `BUSY` does not revoke the grant.

## Timing
- Reset values, applied immediately on `rst_n` low:
  - state `IDLE`, `ptr = 0`, `owner = 0`, `hold_cnt = 0`.
  - `gnt = 0`, `gnt_idx = 0`, `gnt_valid = 0`, `timeout = 0`.
- Grant latency: a request sampled in `IDLE` produces `gnt` on the next edge, one cycle later.
- Release latency: `req[owner]` sampled low clears `gnt` on that edge.
- Turnaround: there is a minimum one idle cycle between consecutive grants, even with back-to-back requests.
- Grant duration: a held grant lasts at most `MAX_HOLD` cycles with `gnt_valid` high.
- `timeout` asserts in the same cycle `gnt_valid` falls.
- Simultaneous release and timeout: treat as a release, with `timeout = 0`.
- Boundary cases:
  - `MAX_HOLD = 1`: a still-requesting owner is revoked after 1 cycle.
  - `MAX_HOLD = 0`: the counter saturates at 255 and never revokes.
- Reset in `BUSY`: grant drops asynchronously and `ptr` returns to 0.

## Structure
- Shared package `arb_pkg` holds:
  - `N_REQ = 8` and `IDX_W = 3`.
  - A state enum `arb_state_t` with values `ARB_IDLE` and `ARB_BUSY`.
- Sub-module `prio_enc8`:
  - Purely combinational 8-to-3 priority encoder; the lowest set bit wins.
  - Outputs `idx[2:0]` and `valid`.
- Top level holds the rotation logic, the FSM, the counter and the output registers.

## Test plan
- Reset: assert `rst_n` = 0 mid-run.
  - Outputs must be `gnt = 0`, `gnt_idx = 0`, `gnt_valid = 0` and `timeout = 0` immediately, without waiting for a clock.
- Single requester: `req = 8'h08` for 5 cycles, then 0.
  - `gnt = 8'h08` and `gnt_idx = 3` from cycle 1.
  - `gnt = 0` the cycle after `req` drops.
  - `ptr` becomes 4.
- Rotation: with `ptr = 0`, hold `req = 8'hFF` and have each owner release after 2 cycles.
  - Grants go to 0,1,2,…,7,0.
  - Each grant is separated by one idle cycle.
- Wrap: with `ptr = 6`, set `req = 8'h21`, i.e. bits 5 and 0.
  - Grant goes to 0 first.
  - After release the grant goes to 5.
- Timeout: with `MAX_HOLD = 4`, hold `req = 8'h01` indefinitely.
  - `gnt_valid` is high for exactly 4 cycles, then `timeout` pulses.
  - The grant returns after 1 idle cycle.
  - If `req` also has bit 1 set, bit 1 is granted next.
- Enable gating: `enable = 0` with `req = 8'h10` gives no grant.
  - Raising `enable` gives `gnt = 8'h10` one cycle later.
  - Dropping `enable` during `BUSY` leaves the grant in place until release.
